// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a one-word
// skid buffer that parks a returned instruction while the pipeline is stalled.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] IF_ID_instr,
  output logic [31:0] IF_ID_pc,
  output logic        IF_ID_valid
);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [31:0] pc_r, pc_nxt_s;
  logic [31:0] instr_r, instr_nxt_s;
  logic [31:0] ipc_r, ipc_nxt_s;
  logic        valid_r, valid_nxt_s;
  logic [31:0] skid_r, skid_nxt_s;
  logic [31:0] pc_inc_s;

  // Low two bits are never set, so the wrap past 32'hFFFFFFFC falls out of 32-bit addition.
  assign pc_inc_s = pc_r + 32'd4;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and next datapath values; a redirect overrides any stall or pending word.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    instr_nxt_s = instr_r;
    ipc_nxt_s   = ipc_r;
    valid_nxt_s = valid_r;
    skid_nxt_s  = skid_r;
    if (branch_taken) begin
      state_nxt_s = FETCH;
      pc_nxt_s    = {branch_target[31:2], 2'b00};
      instr_nxt_s = NOP_INSTR;
      ipc_nxt_s   = 32'h00000000;
      valid_nxt_s = 1'b0;
    end else begin
      case (state_r)
        FETCH: begin
          if (imem_ready) begin
            if (stall) begin
              skid_nxt_s  = imem_rdata;
              state_nxt_s = HOLD;
            end else begin
              instr_nxt_s = imem_rdata;
              ipc_nxt_s   = pc_r;
              valid_nxt_s = 1'b1;
              pc_nxt_s    = pc_inc_s;
            end
          end else if (!stall) begin
            instr_nxt_s = NOP_INSTR;
            valid_nxt_s = 1'b0;
          end else begin
            state_nxt_s = FETCH;
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_nxt_s = skid_r;
            ipc_nxt_s   = pc_r;
            valid_nxt_s = 1'b1;
            pc_nxt_s    = pc_inc_s;
            state_nxt_s = FETCH;
          end else begin
            state_nxt_s = HOLD;
          end
        end
        default: begin
          state_nxt_s = FETCH;
        end
      endcase
    end
  end

  // Datapath registers: PC, IF/ID and skid buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r    <= RESET_PC;
      instr_r <= NOP_INSTR;
      ipc_r   <= 32'h00000000;
      valid_r <= 1'b0;
      skid_r  <= 32'h00000000;
    end else begin
      pc_r    <= pc_nxt_s;
      instr_r <= instr_nxt_s;
      ipc_r   <= ipc_nxt_s;
      valid_r <= valid_nxt_s;
      skid_r  <= skid_nxt_s;
    end
  end

  assign imem_req    = (state_r == FETCH) && !reset;
  assign imem_addr   = pc_r;
  assign PC          = pc_r;
  assign IF_ID_instr = instr_r;
  assign IF_ID_pc    = ipc_r;
  assign IF_ID_valid = valid_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a word-level reference model, plus
// directed scenarios with hand-computed expectations.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset = 1'b1, stall = 1'b0, branch_taken = 1'b0, imem_ready = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_req, IF_ID_valid;
  logic [31:0] imem_addr, imem_rdata, PC, IF_ID_instr, IF_ID_pc;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_rdata, w_pc, w_instr, w_ipc;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5A5, a[15:0]};
  endfunction

  assign imem_rdata = word_of(imem_addr);
  assign w_rdata    = word_of(w_addr);

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h00000000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .PC(PC),
    .IF_ID_instr(IF_ID_instr), .IF_ID_pc(IF_ID_pc), .IF_ID_valid(IF_ID_valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFFFFFC), .NOP_INSTR(NOP)) u_wrap (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(imem_ready), .imem_rdata(w_rdata), .PC(w_pc),
    .IF_ID_instr(w_instr), .IF_ID_pc(w_ipc), .IF_ID_valid(w_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: program-order fetch stream with an optional parked word.
  logic        m_init = 1'b0;
  logic        m_parked;
  logic [31:0] m_parked_word, m_pc, m_instr, m_ipc;
  logic        m_valid;

  always @(posedge clk) begin
    if (reset) begin
      m_init <= 1'b1; m_parked <= 1'b0; m_parked_word <= 32'h0;
      m_pc <= 32'h0; m_instr <= NOP; m_ipc <= 32'h0; m_valid <= 1'b0;
    end else if (branch_taken) begin
      m_parked <= 1'b0; m_pc <= branch_target & 32'hFFFFFFFC;
      m_instr <= NOP; m_ipc <= 32'h0; m_valid <= 1'b0;
    end else if (m_parked) begin
      if (!stall) begin
        m_parked <= 1'b0; m_instr <= m_parked_word; m_ipc <= m_pc;
        m_valid <= 1'b1; m_pc <= m_pc + 32'd4;
      end
    end else if (imem_ready) begin
      if (stall) begin
        m_parked <= 1'b1; m_parked_word <= word_of(m_pc);
      end else begin
        m_instr <= word_of(m_pc); m_ipc <= m_pc; m_valid <= 1'b1; m_pc <= m_pc + 32'd4;
      end
    end else if (!stall) begin
      m_instr <= NOP; m_valid <= 1'b0;
    end
  end

  // Per-cycle comparison of the DUT against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_init) begin
      chk("pc", PC, m_pc);
      chk("imem_addr", imem_addr, m_pc);
      chk("imem_req", {31'd0, imem_req}, {31'd0, !m_parked && !reset});
      chk("if_id_valid", {31'd0, IF_ID_valid}, {31'd0, m_valid});
      chk("if_id_instr", IF_ID_instr, m_instr);
      if (m_valid) chk("if_id_pc", IF_ID_pc, m_ipc);
      chk("pc_align", {30'd0, PC[1:0]}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset and streaming
    reset = 1'b1; tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pc", PC, 32'h0);
    chk("rst_valid", {31'd0, IF_ID_valid}, 32'd0);
    chk("rst_instr", IF_ID_instr, NOP);
    reset = 1'b0; imem_ready = 1'b1; #1;
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stream_ipc", IF_ID_pc, 32'(4 * k));
      chk("stream_valid", {31'd0, IF_ID_valid}, 32'd1);
      chk("stream_instr", IF_ID_instr, word_of(32'(4 * k)));
    end
    chk("stream_pc", PC, 32'd20);

    // Stall while a word returns at PC=8
    reset = 1'b1; tick(); reset = 1'b0; tick(); tick();
    chk("pre_stall_pc", PC, 32'd8);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_ipc", IF_ID_pc, 32'd4);
      chk("stall_instr", IF_ID_instr, word_of(32'd4));
      chk("stall_pc", PC, 32'd8);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
    end
    stall = 1'b0; tick();
    chk("release_ipc", IF_ID_pc, 32'd8);
    chk("release_instr", IF_ID_instr, word_of(32'd8));
    chk("release_pc", PC, 32'd12);

    // Branch out of HOLD discards the parked word
    stall = 1'b1; tick();
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    branch_taken = 1'b1; branch_target = 32'h00000103; tick();
    chk("br_pc", PC, 32'h100);
    chk("br_valid", {31'd0, IF_ID_valid}, 32'd0);
    chk("br_instr", IF_ID_instr, NOP);
    chk("br_ipc", IF_ID_pc, 32'h0);
    branch_taken = 1'b0; stall = 1'b0; #1;
    chk("br_addr", imem_addr, 32'h100);
    chk("br_req", {31'd0, imem_req}, 32'd1);
    tick();
    chk("br_fetch_ipc", IF_ID_pc, 32'h100);
    chk("br_fetch_instr", IF_ID_instr, word_of(32'h100));

    // Memory wait at 0x20
    branch_taken = 1'b1; branch_target = 32'h20; tick();
    branch_taken = 1'b0; imem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("wait_valid", {31'd0, IF_ID_valid}, 32'd0);
      chk("wait_instr", IF_ID_instr, NOP);
      chk("wait_pc", PC, 32'h20);
    end
    imem_ready = 1'b1; tick();
    chk("wait_ipc", IF_ID_pc, 32'h20);
    chk("wait_valid_after", {31'd0, IF_ID_valid}, 32'd1);

    // Reset wins over branch and stall; wrap from 0xFFFFFFFC
    reset = 1'b1; branch_taken = 1'b1; branch_target = 32'h40; stall = 1'b1; tick();
    chk("rbs_pc", PC, 32'h0);
    chk("rbs_valid", {31'd0, IF_ID_valid}, 32'd0);
    chk("rbs_instr", IF_ID_instr, NOP);
    chk("rbs_ipc", IF_ID_pc, 32'h0);
    chk("rbs_req", {31'd0, imem_req}, 32'd0);
    chk("wrap_rst_pc", w_pc, 32'hFFFFFFFC);
    reset = 1'b0; branch_taken = 1'b0; stall = 1'b0; imem_ready = 1'b1; tick();
    chk("wrap_ipc", w_ipc, 32'hFFFFFFFC);
    chk("wrap_instr", w_instr, word_of(32'hFFFFFFFC));
    chk("wrap_pc", w_pc, 32'h0);

    // Randomized traffic checked by the model
    for (int k = 0; k < 3000; k++) begin
      reset         = ($urandom % 64) == 0;
      branch_taken  = ($urandom % 16) == 0;
      branch_target = $urandom;
      stall         = ($urandom % 3) == 0;
      imem_ready    = ($urandom % 4) != 0;
      tick();
    end
    reset = 1'b0; branch_taken = 1'b0; stall = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
